fpu_addsub_pipe: RTL and testbench

Parametrised, pipelined IEEE-754 floating-point adder/subtractor that performs add or subtract per transaction under a runtime op bit.
It has 3 stages with valid/ready flow control and back-pressure, round-to-nearest-even, correct special-value handling and exception flags.
It is the general-purpose FP add/sub datapath for the accelerator FPU cluster, at any EXP_W/MAN_W (single precision by default).

---
 rtl/fpu_pkg.sv | 40 ++++
 rtl/fpu_addsub_pipe_if.sv | 30 +++
 rtl/fpu_lzc.sv | 18 +
 rtl/fpu_addsub_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_fpu_addsub_pipe.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP add/sub pipeline: flag bit positions, special-value
// encodings and the width-independent special-case override carried down the pipe.
package fpu_pkg;

    localparam int FLG_NV = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_NAN  = 2'd1,
        SP_INF  = 2'd2,
        SP_ZERO = 2'd3
    } sp_kind_t;

    // Special result decided at unpack time; overrides the arithmetic path at pack time.
    typedef struct packed {
        sp_kind_t kind;
        logic     sign;
        logic     nv;
    } spec_t;

    // Encodings are returned right-aligned in 64 bits; callers keep the low 1+e+m bits.
    function automatic logic [63:0] fp_qnan(input int e, input int m);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < e; i++) r[m + i] = 1'b1;
        r[m - 1] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] fp_inf(input int e, input int m);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < e; i++) r[m + i] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fpu_addsub_pipe_if.sv
// Operand/result handshake bundle for the FP add/sub pipeline.
interface fpu_addsub_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_z;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_z, out_tag, out_flags
    );

    modport master (
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_z, out_tag, out_flags
    );
endinterface

// File: rtl/fpu_lzc.sv
// Leading-zero counter; returns W when the input is all zeros.
module fpu_lzc #(
    parameter int W = 28,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  d,
    output logic [CW-1:0] cnt
);

    // Ascending scan: the highest set bit is the last to write cnt.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (d[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_addsub_pipe.sv
// Three-stage IEEE-754 add/sub (FTZ, round-to-nearest-even) with valid/ready handshake.
// A single stall enable freezes every stage whenever a held result is not taken.
module fpu_addsub_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    fpu_addsub_pipe_if.slave    io
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int AW = MAN_W + 4;
    localparam int SW = MAN_W + 5;
    localparam int EI = EXP_W + 2;
    localparam int LW = $clog2(SW + 1);

    localparam logic [63:0]          QNAN64 = fp_qnan(EXP_W, MAN_W);
    localparam logic [63:0]          INF64  = fp_inf(EXP_W, MAN_W);
    localparam logic [W-2:0]         QNAN_M = QNAN64[W-2:0];
    localparam logic [W-2:0]         INF_M  = INF64[W-2:0];
    localparam logic signed [EI-1:0] EMAX   = EI'((1 << EXP_W) - 1);
    localparam logic signed [EI-1:0] EZERO  = '0;

    typedef struct packed {
        logic             sign;
        logic             eff_sub;
        logic [EXP_W-1:0] ex;
        logic [AW-1:0]    mx;
        logic [AW-1:0]    my;
        spec_t            sp;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] ex;
        logic [SW-1:0]    sum;
        spec_t            sp;
        logic [TAG_W-1:0] tag;
    } s2_t;

    logic en;
    logic v1, v2, out_valid_q;
    s1_t  s1, s1_d;
    s2_t  s2, s2_d;
    logic [W-1:0]     z_d, out_z_q;
    logic [3:0]       f_d, out_flags_q;
    logic [TAG_W-1:0] out_tag_q;

    assign en            = !out_valid_q || io.out_ready;
    assign io.in_ready   = en;
    assign io.out_valid  = out_valid_q;
    assign io.out_z      = out_z_q;
    assign io.out_tag    = out_tag_q;
    assign io.out_flags  = out_flags_q;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, ex, ey, diff;
    logic [MAN_W-1:0] fa, fb;
    logic [MAN_W:0]   ma, mb, mx, my;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge;
    logic [AW-1:0]    y_ext, y_shr, y_lost;

    assign sa = io.in_a[W-1];
    assign sb = io.in_b[W-1] ^ io.in_sub;
    assign ea = io.in_a[W-2:MAN_W];
    assign eb = io.in_b[W-2:MAN_W];
    assign fa = io.in_a[MAN_W-1:0];
    assign fb = io.in_b[MAN_W-1:0];

    always_comb begin
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (&ea) && (fa == '0);
        b_inf  = (&eb) && (fb == '0);
        a_nan  = (&ea) && (fa != '0);
        b_nan  = (&eb) && (fb != '0);
        ma     = a_zero ? '0 : {1'b1, fa};
        mb     = b_zero ? '0 : {1'b1, fb};
        a_ge   = {ea, ma} >= {eb, mb};
        ex     = a_ge ? ea : eb;
        ey     = a_ge ? eb : ea;
        mx     = a_ge ? ma : mb;
        my     = a_ge ? mb : ma;
        diff   = ex - ey;
        // Bits pushed past the field are ORed into the sticky position; huge shifts leave only sticky.
        y_ext  = {my, 3'b000};
        y_shr  = y_ext >> diff;
        y_lost = y_ext & ~({AW{1'b1}} << diff);

        s1_d         = '0;
        s1_d.sign    = a_ge ? sa : sb;
        s1_d.eff_sub = sa ^ sb;
        s1_d.ex      = ex;
        s1_d.mx      = {mx, 3'b000};
        s1_d.my      = {y_shr[AW-1:1], y_shr[0] | (|y_lost)};
        s1_d.tag     = io.in_tag;
        s1_d.sp.kind = SP_NONE;
        if (a_nan || b_nan) begin
            s1_d.sp.kind = SP_NAN;
            s1_d.sp.nv   = (a_nan && !fa[MAN_W-1]) || (b_nan && !fb[MAN_W-1]);
        end else if (a_inf && b_inf && (sa != sb)) begin
            s1_d.sp.kind = SP_NAN;
            s1_d.sp.nv   = 1'b1;
        end else if (a_inf) begin
            s1_d.sp.kind = SP_INF;
            s1_d.sp.sign = sa;
        end else if (b_inf) begin
            s1_d.sp.kind = SP_INF;
            s1_d.sp.sign = sb;
        end else if (a_zero && b_zero) begin
            s1_d.sp.kind = SP_ZERO;
            s1_d.sp.sign = sa & sb;
        end
    end

    // ---------------- S2: magnitude add/subtract ----------------
    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1.sign;
        s2_d.ex   = s1.ex;
        s2_d.sp   = s1.sp;
        s2_d.tag  = s1.tag;
        s2_d.sum  = s1.eff_sub ? ({1'b0, s1.mx} - {1'b0, s1.my})
                               : ({1'b0, s1.mx} + {1'b0, s1.my});
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [LW-1:0]          lzc, lzc_m1;
    logic [SW-1:0]          shl;
    logic [AW-1:0]          norm;
    logic signed [EI-1:0]   exp_c, exp_n, exp_r, lz_s;
    logic [MAN_W+1:0]       rnd;
    logic [MAN_W-1:0]       frac;
    logic                   grd, rs, rup, nx;

    fpu_lzc #(.W(SW)) u_lzc (.d(s2.sum), .cnt(lzc));

    always_comb begin
        exp_c  = $signed({2'b00, s2.ex});
        lzc_m1 = lzc - LW'(1);
        lz_s   = $signed(EI'(lzc_m1));
        shl    = s2.sum << lzc_m1;
        if (s2.sum[SW-1]) begin
            norm  = {s2.sum[SW-1:2], s2.sum[1] | s2.sum[0]};
            exp_n = exp_c + EI'(1);
        end else begin
            norm  = shl[AW-1:0];
            exp_n = exp_c - lz_s;
        end
        grd  = norm[2];
        rs   = norm[1] | norm[0];
        rup  = grd && (rs || norm[3]);
        nx   = grd || rs;
        rnd  = {1'b0, norm[AW-1:3]} + {{(MAN_W+1){1'b0}}, rup};
        if (rnd[MAN_W+1]) begin
            exp_r = exp_n + EI'(1);
            frac  = rnd[MAN_W:1];
        end else begin
            exp_r = exp_n;
            frac  = rnd[MAN_W-1:0];
        end

        f_d         = '0;
        f_d[FLG_NX] = nx;
        z_d         = {s2.sign, exp_r[EXP_W-1:0], frac};
        if (exp_r >= EMAX) begin
            z_d         = {s2.sign, INF_M};
            f_d[FLG_OF] = 1'b1;
            f_d[FLG_NX] = 1'b1;
        end else if (exp_r <= EZERO) begin
            z_d         = {s2.sign, {(W-1){1'b0}}};
            f_d[FLG_UF] = 1'b1;
            f_d[FLG_NX] = 1'b1;
        end
        if (s2.sum == '0) begin
            z_d = '0;
            f_d = '0;
        end

        case (s2.sp.kind)
            SP_NAN: begin
                z_d         = {1'b0, QNAN_M};
                f_d         = '0;
                f_d[FLG_NV] = s2.sp.nv;
            end
            SP_INF: begin
                z_d = {s2.sp.sign, INF_M};
                f_d = '0;
            end
            SP_ZERO: begin
                z_d = {s2.sp.sign, {(W-1){1'b0}}};
                f_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            out_valid_q <= 1'b0;
            s1          <= '0;
            s2          <= '0;
            out_z_q     <= '0;
            out_tag_q   <= '0;
            out_flags_q <= '0;
        end else if (en) begin
            v1          <= io.in_valid;
            s1          <= s1_d;
            v2          <= v1;
            s2          <= s2_d;
            out_valid_q <= v2;
            out_z_q     <= z_d;
            out_tag_q   <= s2.tag;
            out_flags_q <= f_d;
        end
    end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed scoreboard bench for fpu_addsub_pipe (single precision plus one double-precision case).
module tb_fpu_addsub_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_addsub_pipe_if #(.EXP_W(8),  .MAN_W(23), .TAG_W(4)) ifs ();
    fpu_addsub_pipe_if #(.EXP_W(11), .MAN_W(52), .TAG_W(4)) ifd ();

    fpu_addsub_pipe #(.EXP_W(8),  .MAN_W(23), .TAG_W(4)) dut_s (.clk(clk), .rst(rst), .io(ifs.slave));
    fpu_addsub_pipe #(.EXP_W(11), .MAN_W(52), .TAG_W(4)) dut_d (.clk(clk), .rst(rst), .io(ifd.slave));

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] z;
        logic [3:0]  f;
        logic [3:0]  tag;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] cap_z;
    int          lat;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp_v);
        end
    endtask

    // Scoreboard consumer: a transfer happens at the next rising edge when valid&ready here.
    always @(negedge clk) begin
        if (!rst && ifs.out_valid && ifs.out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 64'(ifs.out_valid), 64'(0));
            end else begin
                mon_e = sb_q.pop_front();
                check("result_z",     64'(ifs.out_z),     64'(mon_e.z));
                check("result_flags", 64'(ifs.out_flags), 64'(mon_e.f));
                check("result_tag",   64'(ifs.out_tag),   64'(mon_e.tag));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [3:0] tag, input logic [31:0] ez, input logic [3:0] ef);
        bit   done;
        exp_t e;
        done = 1'b0;
        e.z = ez;
        e.f = ef;
        e.tag = tag;
        ifs.in_valid = 1'b1;
        ifs.in_a     = a;
        ifs.in_b     = b;
        ifs.in_sub   = sub;
        ifs.in_tag   = tag;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            if (ifs.in_ready) begin
                sb_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        ifs.in_valid = 1'b0;
        if (!done) check("issue_timeout", 64'(ifs.in_ready), 64'(1));
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb_q.size() != 0; n++) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifs.in_valid = 1'b0; ifs.in_a = '0; ifs.in_b = '0; ifs.in_sub = 1'b0; ifs.in_tag = '0;
        ifs.out_ready = 1'b1;
        ifd.in_valid = 1'b0; ifd.in_a = '0; ifd.in_b = '0; ifd.in_sub = 1'b0; ifd.in_tag = '0;
        ifd.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 64'(ifs.out_valid), 64'(0));
        check("rst_out_z",     64'(ifs.out_z),     64'(0));
        check("rst_out_tag",   64'(ifs.out_tag),   64'(0));
        check("rst_out_flags", 64'(ifs.out_flags), 64'(0));
        check("rst_in_ready",  64'(ifs.in_ready),  64'(1));
        check("rst_d_valid",   64'(ifd.out_valid), 64'(0));
        @(posedge clk);
        #1;

        // 1.0 + 2.0, latency counted in rising edges starting with the accept edge
        issue(32'h3F800000, 32'h40000000, 1'b0, 4'h5, 32'h40400000, 4'b0000);
        lat = 1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ifs.out_valid) break;
            @(posedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(3));
        drain();

        // Directed arithmetic and special cases, back-to-back
        issue(32'h3F800000, 32'h3F800000, 1'b1, 4'h1, 32'h00000000, 4'b0000);
        issue(32'h80000000, 32'h80000000, 1'b0, 4'h2, 32'h80000000, 4'b0000);
        issue(32'h3F800000, 32'h33800000, 1'b0, 4'h3, 32'h3F800000, 4'b0001);
        issue(32'h3F800000, 32'h33800001, 1'b0, 4'h4, 32'h3F800001, 4'b0001);
        issue(32'h7F800000, 32'h7F800000, 1'b1, 4'h6, 32'h7FC00000, 4'b1000);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'h7, 32'h7F800000, 4'b0101);
        issue(32'h7F800001, 32'h3F800000, 1'b0, 4'h8, 32'h7FC00000, 4'b1000);
        issue(32'h7FC00000, 32'h3F800000, 1'b0, 4'h9, 32'h7FC00000, 4'b0000);
        issue(32'hFF800000, 32'h3F800000, 1'b0, 4'hA, 32'hFF800000, 4'b0000);
        issue(32'h40400000, 32'h3F800000, 1'b1, 4'hB, 32'h40000000, 4'b0000);
        issue(32'h00800000, 32'h00800001, 1'b1, 4'hC, 32'h80000000, 4'b0011);
        issue(32'h00000000, 32'h3F800000, 1'b0, 4'hD, 32'h3F800000, 4'b0000);
        drain();

        // Back-pressure: four ops issued while the consumer stalls for five cycles
        ifs.out_ready = 1'b0;
        fork
            begin
                issue(32'h3F800000, 32'h3F800000, 1'b0, 4'h1, 32'h40000000, 4'b0000);
                issue(32'h40000000, 32'h40000000, 1'b0, 4'h2, 32'h40800000, 4'b0000);
                issue(32'h40800000, 32'h3F800000, 1'b1, 4'h3, 32'h40400000, 4'b0000);
                issue(32'h3F000000, 32'h3E800000, 1'b0, 4'h4, 32'h3F400000, 4'b0000);
            end
            begin
                for (int n = 0; n < 20; n++) begin
                    @(negedge clk);
                    if (ifs.out_valid) break;
                end
                cap_z = ifs.out_z;
                check("bp_first_z", 64'(cap_z), 64'(32'h40000000));
                repeat (5) begin
                    @(negedge clk);
                    check("bp_z_stable",  64'(ifs.out_z),     64'(cap_z));
                    check("bp_in_ready",  64'(ifs.in_ready),  64'(0));
                    check("bp_out_valid", 64'(ifs.out_valid), 64'(1));
                end
                @(posedge clk);
                #1 ifs.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight
        ifs.out_ready = 1'b0;
        issue(32'h3F800000, 32'h40000000, 1'b0, 4'h1, 32'h40400000, 4'b0000);
        issue(32'h40000000, 32'h40000000, 1'b0, 4'h2, 32'h40800000, 4'b0000);
        issue(32'h40400000, 32'h3F800000, 1'b0, 4'h3, 32'h40800000, 4'b0000);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 64'(ifs.out_valid), 64'(0));
        check("midrst_in_ready",  64'(ifs.in_ready),  64'(1));
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifs.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("no_stale_result", 64'(ifs.out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        issue(32'h3FC00000, 32'h3FC00000, 1'b0, 4'hE, 32'h40400000, 4'b0000);
        drain();

        // Double precision: 1.0 + 2.0
        ifd.in_valid = 1'b1;
        ifd.in_a     = 64'h3FF0000000000000;
        ifd.in_b     = 64'h4000000000000000;
        ifd.in_sub   = 1'b0;
        ifd.in_tag   = 4'h7;
        @(negedge clk);
        check("d_in_ready", 64'(ifd.in_ready), 64'(1));
        @(posedge clk);
        #1 ifd.in_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ifd.out_valid) break;
        end
        check("d_out_valid", 64'(ifd.out_valid), 64'(1));
        check("d_out_z",     ifd.out_z,          64'h4008000000000000);
        check("d_out_flags", 64'(ifd.out_flags), 64'(0));
        check("d_out_tag",   64'(ifd.out_tag),   64'(4'h7));

        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
